// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared encodings for the multi-cycle sequencer.
// Holds FSM state codes, instruction classes, opcode[6:2] patterns and
// ALU operation selects used by the controller and the opcode classifier.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CLS_R      = 3'd0,
      CLS_I      = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_ILL    = 3'd5
   } cls_t;

   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_I      = 5'b00100;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_BR    = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_opcode_classify.sv
// opcode_classify: purely combinational opcode -> instruction class map.
// Anything without opcode[1:0]=11 or with an unknown major opcode is illegal.
module opcode_classify
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [2:0] cls
);

   // Map the major opcode to a class, defaulting to illegal
   always_comb begin
      cls = CLS_ILL;
      if (opcode[1:0] == 2'b11) begin
         case (opcode[6:2])
            OP_R:      cls = CLS_R;
            OP_I:      cls = CLS_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            default:   cls = CLS_ILL;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer.
// Optional retired-instruction counter enabled by MULTICYCLE_CTRL_INSTRET_EN;
// without it instret is tied to zero.
// The first cycle after reset is a quiet cycle: the FSM holds its reset
// state and every output strobe is forced low.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int RESET_STATE_FETCH = 1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [6:0]  opcode,
   input  logic        branch_taken,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        ir_we,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        mem_to_reg,
   output logic [1:0]  alu_op,
   output logic        alu_src,
   output logic        reg_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        trap,
   output logic [2:0]  state_o,
   output logic [31:0] instret
);

   localparam state_t RESET_ST = (RESET_STATE_FETCH != 0) ? ST_FETCH : ST_IDLE;

   state_t     state;
   state_t     nextState;
   cls_t       clsReg;
   cls_t       decodedCls;
   logic [2:0] decodedRaw;
   logic       quietCycle;

   opcode_classify u_classify (
      .opcode (opcode),
      .cls    (decodedRaw)
   );

   assign decodedCls = cls_t'(decodedRaw);
   assign state_o    = state;

   // State register, class latch (captured only in DECODE) and quiet-cycle flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RESET_ST;
         clsReg     <= CLS_ILL;
         quietCycle <= 1'b1;
      end else begin
         state      <= nextState;
         quietCycle <= 1'b0;
         if (state == ST_DECODE) begin
            clsReg <= decodedCls;
         end
      end
   end

   // Next-state and strobe decode from state and latched class
   always_comb begin
      nextState  = state;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = ALU_ADD;
      alu_src    = 1'b0;
      reg_we     = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      trap       = 1'b0;
      if (!quietCycle) begin
         case (state)
            ST_IDLE: begin
               if (start) nextState = ST_FETCH;
            end
            ST_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we     = 1'b1;
                  nextState = ST_DECODE;
               end
            end
            ST_DECODE: begin
               nextState = (decodedCls == CLS_ILL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
               case (clsReg)
                  CLS_R: begin
                     alu_op    = ALU_FUNCT;
                     nextState = ST_WB;
                  end
                  CLS_I: begin
                     alu_op    = ALU_FUNCT;
                     alu_src   = 1'b1;
                     nextState = ST_WB;
                  end
                  CLS_LOAD, CLS_STORE: begin
                     alu_op    = ALU_ADD;
                     alu_src   = 1'b1;
                     nextState = ST_MEM;
                  end
                  CLS_BRANCH: begin
                     alu_op    = ALU_BR;
                     pc_we     = 1'b1;
                     pc_sel    = branch_taken;
                     nextState = ST_FETCH;
                  end
                  default: nextState = ST_TRAP;
               endcase
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (clsReg == CLS_STORE);
               alu_src  = 1'b1;
               if (dmem_ready) begin
                  if (clsReg == CLS_STORE) begin
                     pc_we     = 1'b1;
                     nextState = ST_FETCH;
                  end else begin
                     nextState = ST_WB;
                  end
               end
            end
            ST_WB: begin
               reg_we     = 1'b1;
               pc_we      = 1'b1;
               mem_to_reg = (clsReg == CLS_LOAD);
               nextState  = ST_FETCH;
            end
            ST_TRAP: begin
               trap = 1'b1;
            end
            default: nextState = RESET_ST;
         endcase
      end
   end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
   logic [31:0] instretCount;

   // Count every PC update as one retired instruction, wrapping naturally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instretCount <= 32'd0;
      end else if (pc_we) begin
         instretCount <= instretCount + 32'd1;
      end
   end

   assign instret = instretCount;
`else
   assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// Two instances share stimulus: dutA leaves reset into FETCH, dutB waits in
// IDLE for start. Expected per-cycle outputs are queued as stimulus is driven
// and compared on the falling edge.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  opcode = 7'h00;
   logic        branch_taken = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;

   logic        aImemReq, aIrWe, aDmemReq, aDmemWe, aMemToReg, aAluSrc;
   logic        aRegWe, aPcWe, aPcSel, aTrap;
   logic [1:0]  aAluOp;
   logic [2:0]  aState;
   logic [31:0] aInstret;

   logic        bImemReq, bIrWe, bDmemReq, bDmemWe, bMemToReg, bAluSrc;
   logic        bRegWe, bPcWe, bPcSel, bTrap;
   logic [1:0]  bAluOp;
   logic [2:0]  bState;
   logic [31:0] bInstret;

   multicycle_ctrl #(.RESET_STATE_FETCH(1)) dutA (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
      .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(aImemReq), .ir_we(aIrWe), .dmem_req(aDmemReq), .dmem_we(aDmemWe),
      .mem_to_reg(aMemToReg), .alu_op(aAluOp), .alu_src(aAluSrc), .reg_we(aRegWe),
      .pc_we(aPcWe), .pc_sel(aPcSel), .trap(aTrap), .state_o(aState), .instret(aInstret)
   );

   multicycle_ctrl #(.RESET_STATE_FETCH(0)) dutB (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
      .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(bImemReq), .ir_we(bIrWe), .dmem_req(bDmemReq), .dmem_we(bDmemWe),
      .mem_to_reg(bMemToReg), .alu_op(bAluOp), .alu_src(bAluSrc), .reg_we(bRegWe),
      .pc_we(bPcWe), .pc_sel(bPcSel), .trap(bTrap), .state_o(bState), .instret(bInstret)
   );

   // Free-running clock
   always #5 clk = ~clk;

   logic [14:0] obsA, obsB;
   assign obsA = {aState, aImemReq, aIrWe, aDmemReq, aDmemWe, aMemToReg, aAluOp, aAluSrc, aRegWe, aPcWe, aPcSel, aTrap};
   assign obsB = {bState, bImemReq, bIrWe, bDmemReq, bDmemWe, bMemToReg, bAluOp, bAluSrc, bRegWe, bPcWe, bPcSel, bTrap};

   typedef struct {
      string       tag;
      logic [14:0] vA;
      logic [14:0] vB;
      logic [31:0] ir;
   } rec_t;

   rec_t        sbQueue[$];
   int          errorCount = 0;
   int          checkCount = 0;
   int unsigned instretModel = 0;

   localparam int CLS_R = 0, CLS_I = 1, CLS_LD = 2, CLS_ST = 3, CLS_BR = 4, CLS_ILL = 5;

   function automatic int modelClass(input logic [6:0] op);
      case (op)
         7'h33:   return CLS_R;
         7'h13:   return CLS_I;
         7'h03:   return CLS_LD;
         7'h23:   return CLS_ST;
         7'h63:   return CLS_BR;
         default: return CLS_ILL;
      endcase
   endfunction

   function automatic logic [14:0] mk(input logic [2:0] st, input logic ireq, input logic irwe,
                                      input logic dreq, input logic dwe, input logic m2r,
                                      input logic [1:0] aop, input logic src, input logic rwe,
                                      input logic pwe, input logic psel, input logic trp);
      return {st, ireq, irwe, dreq, dwe, m2r, aop, src, rwe, pwe, psel, trp};
   endfunction

   localparam logic [14:0] B_IDLE = 15'd0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs and queue what both DUTs should show in it
   task automatic cyc(input string tag, input logic [14:0] vA, input logic [14:0] vB,
                      input logic imr, input logic dmr, input logic bt, input logic st);
      rec_t r;
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      imem_ready   = imr;
      dmem_ready   = dmr;
      branch_taken = bt;
      start        = st;
      r.tag = tag;
      r.vA  = vA;
      r.vB  = vB;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
      r.ir  = instretModel;
`else
      r.ir  = 32'd0;
`endif
      sbQueue.push_back(r);
      if (vA[2]) instretModel++;
   endtask

   // Hold reset for one edge (with readies high), then check the quiet cycle
   task automatic applyReset();
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      start      = 1'b0;
      instretModel = 0;
      cyc("postReset", mk(3'd1, 0,0,0,0,0, 2'b00, 0,0,0,0,0), B_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   // Run one instruction through dutA from FETCH, queuing expected cycles
   task automatic applyStimulus(input logic [6:0] op, input int imemWait, input int dmemWait,
                                input logic taken, input bit abortInMem);
      int  c;
      logic rdy;
      logic isSt;
      c = modelClass(op);
      isSt = (c == CLS_ST);
      opcode = op;
      for (int i = 0; i <= imemWait; i++) begin
         rdy = (i == imemWait);
         cyc("fetch", mk(3'd1, 1, rdy, 0,0,0, 2'b00, 0,0,0,0,0), B_IDLE, rdy, 1'b1, 1'b1, 1'b0);
      end
      cyc("decode", mk(3'd2, 0,0,0,0,0, 2'b00, 0,0,0,0,0), B_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
      if (c == CLS_ILL) begin
         for (int i = 0; i < 12; i++)
            cyc("trap", mk(3'd6, 0,0,0,0,0, 2'b00, 0,0,0,0,1), B_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
         return;
      end
      case (c)
         CLS_R:   cyc("execR",  mk(3'd3, 0,0,0,0,0, 2'b10, 0,0,0,0,0), B_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
         CLS_I:   cyc("execI",  mk(3'd3, 0,0,0,0,0, 2'b10, 1,0,0,0,0), B_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
         CLS_BR:  cyc("execBr", mk(3'd3, 0,0,0,0,0, 2'b01, 0,0,1,taken,0), B_IDLE, 1'b1, 1'b1, taken, 1'b0);
         default: cyc("execMem", mk(3'd3, 0,0,0,0,0, 2'b00, 1,0,0,0,0), B_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
      endcase
      if (c == CLS_BR) return;
      if (c == CLS_LD || c == CLS_ST) begin
         for (int j = 0; j <= dmemWait; j++) begin
            rdy = (j == dmemWait) && !abortInMem;
            cyc("mem", mk(3'd4, 0,0,1,isSt,0, 2'b00, 1,0,isSt && rdy,0,0), B_IDLE, 1'b1, rdy, 1'b1, 1'b0);
            if (abortInMem) return;
         end
         if (isSt) return;
      end
      cyc("wb", mk(3'd5, 0,0,0,0, c == CLS_LD, 2'b00, 0,1,1,0,0), B_IDLE, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   // Scoreboard: compare queued expectations against the DUTs mid-cycle
   always @(negedge clk) begin
      rec_t r;
      if (sbQueue.size() > 0) begin
         r = sbQueue.pop_front();
         checkOutput({r.tag, ".A"}, {17'd0, obsA}, {17'd0, r.vA});
         checkOutput({r.tag, ".instret"}, aInstret, r.ir);
         checkOutput({r.tag, ".B"}, {17'd0, obsB}, {17'd0, r.vB});
         checkOutput({r.tag, ".B.instret"}, bInstret, 32'd0);
      end
   end

   initial begin
      $display("[TB] start");
      applyReset();
      applyStimulus(7'h33, 0, 0, 1'b0, 1'b0);   // R-type, zero wait
      applyStimulus(7'h13, 2, 0, 1'b0, 1'b0);   // I-type, slow fetch
      applyStimulus(7'h03, 0, 3, 1'b0, 1'b0);   // load, dmem 3 waits
      applyStimulus(7'h23, 1, 1, 1'b0, 1'b0);   // store
      applyStimulus(7'h63, 0, 0, 1'b1, 1'b0);   // branch taken
      applyStimulus(7'h63, 0, 0, 1'b0, 1'b0);   // branch not taken
      applyStimulus(7'h23, 0, 2, 1'b0, 1'b1);   // store, reset mid-MEM
      applyReset();
      applyStimulus(7'h33, 0, 0, 1'b0, 1'b0);
      applyStimulus(7'h7F, 0, 0, 1'b0, 1'b0);   // illegal major opcode
      applyReset();
      applyStimulus(7'h32, 0, 0, 1'b0, 1'b0);   // low bits 10
      applyReset();
      // dutB leaves IDLE only after a start pulse
      cyc("startB", mk(3'd1, 1,0,0,0,0, 2'b00, 0,0,0,0,0), B_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc("bFetch", mk(3'd1, 1,0,0,0,0, 2'b00, 0,0,0,0,0),
          mk(3'd1, 1,0,0,0,0, 2'b00, 0,0,0,0,0), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("bFetch", mk(3'd1, 1,0,0,0,0, 2'b00, 0,0,0,0,0),
          mk(3'd1, 1,0,0,0,0, 2'b00, 0,0,0,0,0), 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("sbDrain", sbQueue.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I-subset core; drives the datapath one instruction at a time.
- Sequence per instruction: fetch → decode → execute → memory → writeback.
- Takes the instruction opcode from the instruction register and issues per-state control strobes.
- Handshakes with instruction and data memory through req/ready pairs; ready may arrive any number of cycles after req.

Parameters:
- RESET_STATE_FETCH, 1: 1 = leave reset directly into FETCH; 0 = hold in IDLE until start=1.

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  leave IDLE (only used when RESET_STATE_FETCH=0)
- opcode  in  7  instruction[6:0] from the instruction register
- branch_taken  in  1  ALU compare result, valid in EXEC
- imem_ready  in  1  instruction-memory data valid
- dmem_ready  in  1  data-memory access complete
- imem_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load strobe
- dmem_req  out  1  data-memory request
- dmem_we  out  1  data-memory write (valid with dmem_req)
- mem_to_reg  out  1  writeback source: 1 = load data, 0 = ALU
- alu_op  out  2  00 add (address), 01 branch compare, 10 funct-decoded
- alu_src  out  1  ALU B operand: 1 = immediate, 0 = rs2
- reg_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  1  1 = branch target, 0 = PC+4
- trap  out  1  illegal opcode detected; sticky
- state_o  out  3  current state, for debug
- instret  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state ← FETCH if RESET_STATE_FETCH=1, else IDLE.
  - All strobes 0; alu_op=00; trap=0; instret=0.
  - Reset mid-operation abandons the instruction. No strobe is asserted on the cycle after reset.
- States (3-bit): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all outputs 0; start=1 → FETCH.
- FETCH:
  - imem_req=1, held until imem_ready.
  - On the cycle imem_ready=1: ir_we=1, then → DECODE.
- DECODE: classify the opcode. If opcode[1:0]≠11, the instruction is illegal. Otherwise decode opcode[6:2]:
  - 01100: R-type
  - 00100: I-type
  - 00000: load
  - 01000: store
  - 11000: branch
  - any other value: illegal
- DECODE transitions: legal → EXEC; illegal → TRAP.
- EXEC, by class:
  - R-type: alu_op=10, alu_src=0 → WB.
  - I-type: alu_op=10, alu_src=1 → WB.
  - Load/store: alu_op=00, alu_src=1 → MEM.
  - Branch: alu_op=01, alu_src=0, pc_we=1, pc_sel=branch_taken → FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for store; alu_op=00 and alu_src=1 held; all held until dmem_ready.
  - On dmem_ready, store: pc_we=1, pc_sel=0 → FETCH.
  - On dmem_ready, load: → WB.
- WB: reg_we=1, pc_we=1, pc_sel=0, mem_to_reg=(class==load) → FETCH.
- TRAP: trap=1; all other strobes 0. Remain in TRAP until reset.
- Strobes are Moore outputs registered from state/class, except:
  - ir_we: combinational with imem_ready in FETCH.
  - pc_sel: combinational with branch_taken in EXEC.
- Instruction class is latched in DECODE and held until the next DECODE.
- Minimum latency with zero-wait memories (ready in the cycle of req):
  - branch: 3 cycles
  - R/I/store: 4 cycles
  - load: 5 cycles
- pc_we pulses exactly once per retired instruction.
- Ready asserted outside its wait state is ignored.

Optional Feature:
- Macro: MULTICYCLE_CTRL_INSTRET_EN.
- Defined:
  - instret increments by 1 on every cycle pc_we=1.
  - Wraps 0xFFFFFFFF → 0.
  - Cleared by reset.
- Undefined: instret tied to 0; no counter flops synthesized.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state encodings
  - class enum (CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILL)
  - opcode[6:2] constants
  - alu_op constants
- Sub-module opcode_classify (combinational opcode → class) is natural; it also serves future single-cycle decode.

Test Plan:
- R-type 0x33, imem_ready and dmem_ready tied 1 → states 1,2,3,5,1; reg_we and pc_we high in WB only; alu_op=10; 4 cycles.
- Load 0x03, dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; WB has mem_to_reg=1; instret +1 (macro on).
- Branch 0x63, branch_taken=1 → pc_we=1, pc_sel=1 in EXEC; no reg_we; back to FETCH after 3 cycles.
- Opcode 0x7F, then opcode 0x32 (low bits 10) after reset → TRAP, trap=1 sticky for 10+ cycles; no pc_we/reg_we.
- rst_n=0 during MEM of a store → next cycle state=FETCH, dmem_req=0, instret=0.
- RESET_STATE_FETCH=0: stays IDLE with imem_req=0 until start pulse; FETCH the cycle after start=1.
